// File: rtl/pulp_clock_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pulp_clock_div_pkg
//  Description : Shared types and helpers for the programmable clock-divider
//                controller: FSM state encoding, ratio clamping and the
//                high-phase length of a divided period.
//  Revision    : 1.0 - initial release
// ============================================================================
package pulp_clock_div_pkg;

  // Two-state controller: idle (divided clock parked low) or running.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Ratios 0 and 1 cannot produce a distinct high and low phase, so they are
  // promoted to the smallest legal ratio.
  function automatic int unsigned clamp_div(input int unsigned n);
    return (n < 32'd2) ? 32'd2 : n;
  endfunction

  // High phase is the longer half for odd ratios: N=3 -> 2, N=255 -> 128.
  // Evaluated in 32 bits so (N+1) never overflows the ratio width.
  function automatic int unsigned high_len(input int unsigned n);
    return (n + 32'd1) >> 1;
  endfunction

endpackage : pulp_clock_div_pkg
`default_nettype wire

// File: rtl/pulp_clock_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pulp_clock_div_ctrl
//  Description : Programmable integer clock-divider controller. Produces a
//                registered divided clock, a per-period strobe and a busy
//                flag. New ratios arrive over a valid/ready handshake, are
//                held as a single pending entry and are applied only at a
//                period boundary so the divided clock never glitches.
//  Ports       : clk_i        source clock
//                rst_i        asynchronous reset, active-high
//                en_i         run request (level)
//                div_i        requested ratio (0/1 clamped to 2)
//                div_valid_i  div_i valid
//                div_ready_o  a ratio can be accepted (no ratio pending)
//                clk_div_o    registered divided clock
//                period_o     one-cycle pulse per divided-clock rising edge
//                busy_o       controller is running
//                div_q_o      ratio currently in effect
//  Revision    : 1.0 - initial release
// ============================================================================
module pulp_clock_div_ctrl
  import pulp_clock_div_pkg::*;
#(
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned RESET_DIV = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_valid_i,
  output logic             div_ready_o,
  output logic             clk_div_o,
  output logic             period_o,
  output logic             busy_o,
  output logic [DIV_W-1:0] div_q_o
);

  localparam logic [DIV_W-1:0] C_RESET_DIV = DIV_W'(clamp_div(RESET_DIV));

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_div_q, clk_div_d;
  logic             period_q, period_d;

  logic             w_last;
  logic             w_start;
  logic             w_xfer;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] w_high;
  logic [DIV_W-1:0] w_div_clamped;

  // div_q is always >= 2, so div_q-1 never underflows.
  assign w_last        = (cnt_q == (div_q - 1'b1));
  // A period starts either from IDLE or at the wrap point of a running period.
  assign w_start       = en_i && ((state_q == IDLE) || w_last);
  // Only one ratio may wait; ready is simply "nothing pending".
  assign w_xfer        = div_valid_i && !pend_vld_q;
  assign w_cnt_nxt     = cnt_q + 1'b1;
  assign w_high        = DIV_W'(high_len(32'(div_q)));
  assign w_div_clamped = DIV_W'(clamp_div(32'(div_i)));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    clk_div_d  = clk_div_q;
    period_d   = 1'b0;

    // A transfer can only happen while nothing is pending, so it never
    // collides with the pending entry being consumed below. A ratio taken
    // on a start cycle therefore waits for the following boundary.
    if (w_xfer) begin
      pend_d     = w_div_clamped;
      pend_vld_d = 1'b1;
    end

    if (w_start) begin
      state_d   = RUN;
      cnt_d     = '0;
      clk_div_d = 1'b1;
      period_d  = 1'b1;
      if (pend_vld_q) begin
        div_d      = pend_q;
        pend_vld_d = 1'b0;
      end
    end else if (state_q == RUN) begin
      if (w_last) begin
        // en_i low at the final cycle: finish the low phase and park.
        state_d   = IDLE;
        cnt_d     = '0;
        clk_div_d = 1'b0;
      end else begin
        cnt_d     = w_cnt_nxt;
        clk_div_d = (w_cnt_nxt < w_high);
      end
    end
  end

  // The asynchronous reset drops clk_div_o immediately; the downstream
  // domain is held in reset as well, so a truncated high phase is harmless.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= C_RESET_DIV;
      pend_q     <= C_RESET_DIV;
      pend_vld_q <= 1'b0;
      clk_div_q  <= 1'b0;
      period_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_div_q  <= clk_div_d;
      period_q   <= period_d;
    end
  end

  assign div_ready_o = !pend_vld_q;
  assign clk_div_o   = clk_div_q;
  assign period_o    = period_q;
  assign busy_o      = (state_q == RUN);
  assign div_q_o     = div_q;

endmodule : pulp_clock_div_ctrl
`default_nettype wire

// File: tb/tb_pulp_clock_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulp_clock_div_ctrl
//  Description : Self-checking bench for pulp_clock_div_ctrl. A behavioural
//                model tracks the running flag, position within the current
//                period, the ratio in effect and a one-deep pending queue;
//                the expected waveform is derived from those with plain
//                arithmetic. Directed steps cover the documented scenarios,
//                followed by a randomized run and an asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pulp_clock_div_ctrl;

  localparam int unsigned DIV_W     = 8;
  localparam int unsigned RESET_DIV = 2;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             en_i;
  logic [DIV_W-1:0] div_i;
  logic             div_valid_i;
  logic             div_ready_o;
  logic             clk_div_o;
  logic             period_o;
  logic             busy_o;
  logic [DIV_W-1:0] div_q_o;

  int vectors     = 0;
  int miscompares = 0;

  pulp_clock_div_ctrl #(
    .DIV_W     (DIV_W),
    .RESET_DIV (RESET_DIV)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .div_i       (div_i),
    .div_valid_i (div_valid_i),
    .div_ready_o (div_ready_o),
    .clk_div_o   (clk_div_o),
    .period_o    (period_o),
    .busy_o      (busy_o),
    .div_q_o     (div_q_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------------------------------------------------------- model
  bit m_run;
  int m_idx;
  int m_n;
  bit m_per;
  int pend[$];

  function automatic int clamp(input int n);
    return (n < 2) ? 2 : n;
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_run = 1'b0;
      m_idx = 0;
      m_n   = clamp(RESET_DIV);
      m_per = 1'b0;
      pend.delete();
    end else begin
      bit acc;
      int nv;
      acc = div_valid_i && (pend.size() == 0);
      nv  = clamp(int'(div_i));
      if (!m_run || m_idx == m_n - 1) begin
        if (en_i) begin
          if (pend.size() != 0) m_n = pend.pop_front();
          m_run = 1'b1;
          m_idx = 0;
          m_per = 1'b1;
        end else begin
          m_run = 1'b0;
          m_idx = 0;
          m_per = 1'b0;
        end
      end else begin
        m_idx = m_idx + 1;
        m_per = 1'b0;
      end
      if (acc) pend.push_back(nv);
    end
  end

  function automatic bit exp_clk();
    return m_run && (m_idx < (m_n + 1) / 2);
  endfunction

  // --------------------------------------------------------------- checks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".clk"},   32'(clk_div_o),   32'(exp_clk()));
    check({tag, ".per"},   32'(period_o),    32'(m_per));
    check({tag, ".busy"},  32'(busy_o),      32'(m_run));
    check({tag, ".divq"},  32'(div_q_o),     32'(m_n));
    check({tag, ".ready"}, 32'(div_ready_o), 32'(pend.size() == 0));
  endtask

  task automatic step(input logic en, input logic vld, input logic [DIV_W-1:0] d);
    en_i        = en;
    div_valid_i = vld;
    div_i       = d;
    @(posedge clk_i);
    @(negedge clk_i);
    check_model("step");
  endtask

  // Steps `len` cycles and compares clk_div_o against a fixed bit pattern
  // (MSB is the first cycle).
  task automatic pat(input string tag, input logic en, input int len, input logic [31:0] bits);
    for (int i = 0; i < len; i++) begin
      step(en, 1'b0, '0);
      check(tag, 32'(clk_div_o), 32'(bits[len-1-i]));
    end
  endtask

  task automatic wait_ready(input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 600 && !ok; k++) begin
      if (pend.size() == 0) ok = 1'b1;
      else step(1'b1, 1'b0, '0);
    end
    check({tag, ".timeout"}, 32'(ok), 32'd1);
  endtask

  // Runs until ratio `n` is in effect and the model is at cycle `idx`.
  task automatic wait_pos(input string tag, input int n, input int idx);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 600 && !ok; k++) begin
      if (m_run && m_n == n && m_idx == idx) ok = 1'b1;
      else step(1'b1, 1'b0, '0);
    end
    check({tag, ".timeout"}, 32'(ok), 32'd1);
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    rst_i       = 1'b1;
    en_i        = 1'b0;
    div_i       = '0;
    div_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);

    // Reset values
    check("rst.clk",   32'(clk_div_o),   32'd0);
    check("rst.per",   32'(period_o),    32'd0);
    check("rst.busy",  32'(busy_o),      32'd0);
    check("rst.ready", 32'(div_ready_o), 32'd1);
    check("rst.divq",  32'(div_q_o),     32'd2);
    rst_i = 1'b0;

    // Default ratio 2 straight out of reset
    pat("n2", 1'b1, 6, 32'b101010);
    check("n2.divq", 32'(div_q_o), 32'd2);

    // Stop: final cycle sampled with en_i low
    step(1'b0, 1'b0, '0);
    check("stop.busy", 32'(busy_o), 32'd0);

    // Ratio 3 accepted in IDLE, applied at the next start
    step(1'b0, 1'b1, 8'd3);
    check("n3.pend_ready", 32'(div_ready_o), 32'd0);
    pat("n3", 1'b1, 6, 32'b110110);
    check("n3.divq", 32'(div_q_o), 32'd3);

    // Clamp of 0 and 1, with the second request stalled
    step(1'b1, 1'b1, 8'd0);
    step(1'b1, 1'b1, 8'd1);
    check("clamp.stall", 32'(div_ready_o), 32'd0);
    repeat (8) step(1'b1, 1'b1, 8'd1);
    repeat (6) step(1'b1, 1'b0, '0);
    check("clamp.divq", 32'(div_q_o), 32'd2);

    // N=4 -> N=7 accepted on a period-start edge
    wait_ready("n4");
    step(1'b1, 1'b1, 8'd4);
    wait_pos("n4.align", 4, 3);
    step(1'b1, 1'b1, 8'd7);
    check("n4to7.first", 32'(clk_div_o), 32'd1);
    pat("n4to7", 1'b1, 10, 32'b1001111000);
    check("n4to7.divq", 32'(div_q_o), 32'd7);

    // N=5, drop en_i at cnt=1
    wait_ready("n5");
    step(1'b1, 1'b1, 8'd5);
    wait_pos("n5.align", 5, 0);
    step(1'b1, 1'b0, '0);
    check("n5stop.cnt1", 32'(clk_div_o), 32'd1);
    pat("n5stop", 1'b0, 4, 32'b1000);
    step(1'b0, 1'b0, '0);
    check("n5stop.clk",  32'(clk_div_o), 32'd0);
    check("n5stop.busy", 32'(busy_o),    32'd0);

    // N=5, drop at cnt=1 and re-raise at cnt=3: seamless wrap
    step(1'b1, 1'b0, '0);
    check("n5re.start", 32'(period_o), 32'd1);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    check("n5re.wrap_per",  32'(period_o),  32'd1);
    check("n5re.wrap_busy", 32'(busy_o),    32'd1);
    check("n5re.wrap_clk",  32'(clk_div_o), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [DIV_W-1:0] d;
      int r;
      r = int'($urandom % 32);
      if (r < 4)        d = DIV_W'(r % 2);
      else if (r == 31) d = 8'd255;
      else              d = DIV_W'($urandom_range(2, 12));
      step(($urandom % 16) != 0, ($urandom % 4) == 0, d);
    end

    // Asynchronous reset in the middle of a high phase with a ratio pending
    wait_ready("rst9");
    step(1'b1, 1'b1, 8'd9);
    wait_pos("rst9.align", 9, 0);
    step(1'b1, 1'b1, 8'd6);
    check("arst.pre_clk",   32'(clk_div_o),   32'd1);
    check("arst.pre_ready", 32'(div_ready_o), 32'd0);
    #2 rst_i = 1'b1;
    #1;
    check("arst.clk",   32'(clk_div_o),   32'd0);
    check("arst.per",   32'(period_o),    32'd0);
    check("arst.busy",  32'(busy_o),      32'd0);
    check("arst.ready", 32'(div_ready_o), 32'd1);
    check("arst.divq",  32'(div_q_o),     32'd2);
    en_i        = 1'b0;
    div_valid_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    check_model("arst.hold");
    // Pending ratio 6 was discarded: restart runs at the reset ratio
    pat("arst.n2", 1'b1, 4, 32'b1010);
    check("arst.n2divq", 32'(div_q_o), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_pulp_clock_div_ctrl
`default_nettype wire
